// File: rtl/keypad_operand_reader.sv
// keypad_operand_reader: scans a 4x4 active-low keypad, debounces presses and
// builds a two-digit decimal operand that is committed with '#'.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   row_in        keypad rows, active-low, asynchronous to clk
//   col_drive     keypad columns, one-hot-low
//   entry_value   binary value of digits keyed so far (0..99)
//   digit_count   digits accepted in the current entry (0..2)
//   operand       last committed operand
//   operand_valid one-cycle pulse when operand updates
//   key_strobe    one-cycle pulse per accepted key
//   key_code      code of the last accepted key
module keypad_operand_reader #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_drive,
    output logic [6:0] entry_value,
    output logic [1:0] digit_count,
    output logic [6:0] operand,
    output logic       operand_valid,
    output logic       key_strobe,
    output logic [3:0] key_code
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [1:0] S_SCAN     = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_ACCEPT   = 2'd2;
    localparam logic [1:0] S_RELEASE  = 2'd3;

    logic [1:0]    state;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    pattern;
    logic [1:0]    col;
    logic [DW-1:0] div;
    logic [CW-1:0] cnt;
    logic          tick;
    logic          rows_idle;
    logic          cnt_last;
    logic [1:0]    row_idx;
    logic [3:0]    code;
    logic [6:0]    entry_next;

    assign tick      = (div == DW'(SCAN_DIV - 1));
    assign rows_idle = &sync2;
    assign cnt_last  = (cnt == CW'(DEBOUNCE_CNT - 1));
    assign col_drive = ~(4'b0001 << col);

    // Lowest low row wins when several rows are pulled down together.
    always_comb begin
        row_idx = 2'd3;
        if (!pattern[0])
            row_idx = 2'd0;
        else if (!pattern[1])
            row_idx = 2'd1;
        else if (!pattern[2])
            row_idx = 2'd2;
    end

    always_comb begin
        code = 4'h0;
        case ({row_idx, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
    end

    // Only used while fewer than two digits are held, so entry_value <= 9
    // and the result never exceeds 99.
    assign entry_next = entry_value * 7'd10 + {3'b000, code};

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_SCAN;
            sync1         <= 4'b1111;
            sync2         <= 4'b1111;
            pattern       <= 4'b1111;
            col           <= 2'd0;
            div           <= '0;
            cnt           <= '0;
            entry_value   <= 7'd0;
            digit_count   <= 2'd0;
            operand       <= 7'd0;
            operand_valid <= 1'b0;
            key_strobe    <= 1'b0;
            key_code      <= 4'h0;
        end else begin
            sync1         <= row_in;
            sync2         <= sync1;
            key_strobe    <= 1'b0;
            operand_valid <= 1'b0;
            div           <= tick ? '0 : div + 1'b1;

            case (state)
                S_SCAN: begin
                    if (tick) begin
                        if (rows_idle) begin
                            col <= col + 2'd1;
                        end else begin
                            pattern <= sync2;
                            cnt     <= '0;
                            state   <= S_DEBOUNCE;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (tick) begin
                        if (sync2 == pattern) begin
                            if (cnt_last) begin
                                cnt   <= '0;
                                state <= S_ACCEPT;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            cnt   <= '0;
                            col   <= col + 2'd1;
                            state <= S_SCAN;
                        end
                    end
                end
                S_ACCEPT: begin
                    key_strobe <= 1'b1;
                    key_code   <= code;
                    cnt        <= '0;
                    state      <= S_RELEASE;
                    if (code <= 4'h9) begin
                        if (digit_count < 2'd2) begin
                            entry_value <= entry_next;
                            digit_count <= digit_count + 2'd1;
                        end
                    end else if (code == 4'hE) begin
                        entry_value <= 7'd0;
                        digit_count <= 2'd0;
                    end else if (code == 4'hF) begin
                        operand       <= entry_value;
                        operand_valid <= 1'b1;
                        entry_value   <= 7'd0;
                        digit_count   <= 2'd0;
                    end
                end
                S_RELEASE: begin
                    if (tick) begin
                        if (!rows_idle) begin
                            cnt <= '0;
                        end else if (cnt_last) begin
                            cnt   <= '0;
                            state <= S_SCAN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_operand_reader.sv
// tb_keypad_operand_reader: directed bench for keypad_operand_reader with a
// behavioural 4x4 keypad model driving rows from the column lines.
module tb_keypad_operand_reader;

    logic       clk;
    logic       reset;
    logic [3:0] row_in;
    logic [3:0] col_drive;
    logic [6:0] entry_value;
    logic [1:0] digit_count;
    logic [6:0] operand;
    logic       operand_valid;
    logic       key_strobe;
    logic [3:0] key_code;

    keypad_operand_reader #(
        .SCAN_DIV(4),
        .DEBOUNCE_CNT(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .row_in(row_in),
        .col_drive(col_drive),
        .entry_value(entry_value),
        .digit_count(digit_count),
        .operand(operand),
        .operand_valid(operand_valid),
        .key_strobe(key_strobe),
        .key_code(key_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: the pressed key pulls its row low while its column is driven.
    logic [3:0] key;
    logic       key_down;

    function automatic logic [3:0] key_at(input int r, input int c);
        logic [3:0] map [16];
        map = '{4'h1, 4'h2, 4'h3, 4'hA,
                4'h4, 4'h5, 4'h6, 4'hB,
                4'h7, 4'h8, 4'h9, 4'hC,
                4'hE, 4'h0, 4'hF, 4'hD};
        return map[r*4 + c];
    endfunction

    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (key_down && key_at(r, c) == key && !col_drive[c])
                    row_in[r] = 1'b0;
    end

    int strobes;
    int valids;
    initial begin
        strobes = 0;
        valids  = 0;
    end
    always @(negedge clk) begin
        if (key_strobe)
            strobes++;
        if (operand_valid)
            valids++;
    end

    int n_checks;
    int n_fail;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    typedef struct {
        logic [3:0] k;
        int         hold;
        int         entry;
        int         count;
        int         oper;
        int         vinc;
    } vec_t;

    vec_t vecs [17];
    int   s0;
    int   v0;

    initial begin
        vecs = '{
            '{4'h9, 10,  9, 1,  0, 0},
            '{4'h8, 10, 98, 2,  0, 0},
            '{4'hF, 10,  0, 0, 98, 1},
            '{4'h5, 10,  5, 1, 98, 0},
            '{4'h6, 10, 56, 2, 98, 0},
            '{4'h7, 10, 56, 2, 98, 0},
            '{4'hF, 10,  0, 0, 56, 1},
            '{4'h4, 10,  4, 1, 56, 0},
            '{4'hE, 10,  0, 0, 56, 0},
            '{4'hF, 10,  0, 0,  0, 1},
            '{4'hA, 10,  0, 0,  0, 0},
            '{4'h3, 50,  3, 1,  0, 0},
            '{4'hF, 10,  0, 0,  3, 1},
            '{4'h0, 10,  0, 1,  3, 0},
            '{4'h7, 10,  7, 2,  3, 0},
            '{4'hF, 10,  0, 0,  7, 1},
            '{4'h5, 10,  5, 1,  7, 0}
        };
        n_checks = 0;
        n_fail   = 0;
        key      = 4'h0;
        key_down = 1'b0;
        reset    = 1'b1;

        // Reset state
        cycles(2);
        #1;
        check("rst_col", col_drive, 4'b1110);
        check("rst_entry", entry_value, 0);
        check("rst_count", digit_count, 0);
        check("rst_oper", operand, 0);
        check("rst_strobe", key_strobe, 0);
        check("rst_code", key_code, 0);
        reset = 1'b0;

        // Idle scan: one column per 4 cycles
        s0 = strobes;
        cycles(2);
        #1;
        check("idle_c0", col_drive, 4'b1110);
        cycles(4);
        #1;
        check("idle_c1", col_drive, 4'b1101);
        cycles(4);
        #1;
        check("idle_c2", col_drive, 4'b1011);
        cycles(4);
        #1;
        check("idle_c3", col_drive, 4'b0111);
        cycles(4);
        #1;
        check("idle_wrap", col_drive, 4'b1110);
        cycles(40);
        check("idle_strobes", strobes - s0, 0);

        // One-period glitch
        s0 = strobes;
        key = 4'hA;
        key_down = 1'b1;
        cycles(4);
        key_down = 1'b0;
        cycles(80);
        check("glitch_strobes", strobes - s0, 0);

        // Bounce for two periods, then a clean hold
        s0 = strobes;
        key_down = 1'b1;
        cycles(4);
        key_down = 1'b0;
        cycles(4);
        key_down = 1'b1;
        cycles(4);
        key_down = 1'b0;
        cycles(4);
        key_down = 1'b1;
        cycles(40);
        key_down = 1'b0;
        cycles(48);
        check("bounce_strobes", strobes - s0, 1);
        check("bounce_code", key_code, 4'hA);

        // Table of clean presses
        for (int i = 0; i < 17; i++) begin
            s0 = strobes;
            v0 = valids;
            key = vecs[i].k;
            key_down = 1'b1;
            cycles(vecs[i].hold * 4);
            key_down = 1'b0;
            cycles(48);
            #1;
            check($sformatf("v%0d_strobes", i), strobes - s0, 1);
            check($sformatf("v%0d_code", i), key_code, vecs[i].k);
            check($sformatf("v%0d_entry", i), entry_value, vecs[i].entry);
            check($sformatf("v%0d_count", i), digit_count, vecs[i].count);
            check($sformatf("v%0d_oper", i), operand, vecs[i].oper);
            check($sformatf("v%0d_valid", i), valids - v0, vecs[i].vinc);
        end

        // Reset clears a non-empty entry and a committed operand
        @(negedge clk);
        reset = 1'b1;
        cycles(2);
        #1;
        check("rst2_entry", entry_value, 0);
        check("rst2_count", digit_count, 0);
        check("rst2_oper", operand, 0);
        check("rst2_code", key_code, 0);
        check("rst2_col", col_drive, 4'b1110);
        reset = 1'b0;

        // Reset while 7 is debouncing abandons the key
        s0 = strobes;
        key = 4'h7;
        key_down = 1'b1;
        cycles(10);
        @(negedge clk);
        reset = 1'b1;
        cycles(2);
        #1;
        check("rstdb_col", col_drive, 4'b1110);
        check("rstdb_strobe", key_strobe, 0);
        check("rstdb_entry", entry_value, 0);
        key_down = 1'b0;
        reset = 1'b0;
        cycles(120);
        check("rstdb_strobes", strobes - s0, 0);
        check("rstdb_entry2", entry_value, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
